// File: rtl/transition_detect_sched_pkg.sv
// -----------------------------------------------------------------------------
// transition_detect_sched_pkg
//   Shared definitions for the time-multiplexed transition detector:
//   per-channel detector context encodings, scheduler state encoding and the
//   default channel count.
// -----------------------------------------------------------------------------
package transition_detect_sched_pkg;

  // Default number of requester channels (power of two, 2..16).
  localparam int NUM_CH_DEFAULT = 4;

  // Per-channel detector context. The unused code 2'b11 behaves as CTX_A.
  typedef enum logic [1:0] {
    CTX_A = 2'b00,  // no history
    CTX_B = 2'b01,  // last sampled level was 0
    CTX_C = 2'b10   // last sampled level was 1
  } ctx_t;

  // Scheduler state, also exported on the debug port of the top.
  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'b00,
    SCHED_SERVE = 2'b01,
    SCHED_EMIT  = 2'b10
  } sched_state_t;

endpackage : transition_detect_sched_pkg

// File: rtl/transition_detect_sched_core.sv
// -----------------------------------------------------------------------------
// trans_detect_core
//   Purely combinational transition-detector step, shared by all channels.
//   Given a channel's stored context and its freshly sampled input bit it
//   returns the context to store back and whether a level transition occurred.
//
// Ports
//   i_state      [1:0]  stored context (A=00, B=01, C=10, 11 treated as A)
//   i_in                sampled input level
//   o_next_state [1:0]  context to write back
//   o_event             1 when the input differs from a known previous level
// -----------------------------------------------------------------------------
module trans_detect_core
  import transition_detect_sched_pkg::*;
(
  input  logic [1:0] i_state,
  input  logic       i_in,
  output logic [1:0] o_next_state,
  output logic       o_event
);

  always_comb begin
    o_event      = 1'b0;
    // The next context only records the latest level, whatever the history.
    o_next_state = i_in ? CTX_C : CTX_B;
    case (i_state)
      CTX_B:   o_event = i_in;
      CTX_C:   o_event = ~i_in;
      default: o_event = 1'b0;  // A or the unused code: no history yet
    endcase
  end

endmodule : trans_detect_core

// File: rtl/transition_detect_sched.sv
// -----------------------------------------------------------------------------
// transition_detect_sched
//   Round-robin scheduler that time-multiplexes one transition detector over
//   NUM_CH requester channels. Each channel owns a 2-bit context register.
//   A service is IDLE (pick a requester) -> SERVE (ack pulse, sample ch_in,
//   update context) -> optional EMIT (present the event until accepted).
//
// Handshake: the event is transferred on a rising edge where evt_valid and
//   evt_ready are both high. While evt_valid is high, evt_ch and evt_level do
//   not change; evt_valid never drops without a transfer except on reset.
//
// Ports
//   clk                      rising-edge clock
//   reset                    asynchronous, active-low reset
//   ch_req    [NUM_CH-1:0]   per-channel level request, held until acked
//   ch_in     [NUM_CH-1:0]   per-channel data, sampled in that channel's ack cycle
//   ch_ack    [NUM_CH-1:0]   one-hot one-cycle pulse marking the sample cycle
//   ctx_clr   [NUM_CH-1:0]   synchronous per-channel context clear to A
//   evt_valid                transition event pending
//   evt_ready                consumer accepts the event
//   evt_ch    [IW-1:0]       channel index of the pending event
//   evt_level                new level (1 = rise, 0 = fall)
//   ctx_state [2*NUM_CH-1:0] per-channel context, channel k at [2k+1:2k]
//   dbg_state [1:0]          scheduler state (IDLE/SERVE/EMIT)
// -----------------------------------------------------------------------------
module transition_detect_sched
  import transition_detect_sched_pkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEFAULT,
  localparam int IW     = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     ch_req,
  input  logic [NUM_CH-1:0]     ch_in,
  output logic [NUM_CH-1:0]     ch_ack,
  input  logic [NUM_CH-1:0]     ctx_clr,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [IW-1:0]         evt_ch,
  output logic                  evt_level,
  output logic [2*NUM_CH-1:0]   ctx_state,
  output logic [1:0]            dbg_state
);

  sched_state_t          r_state;
  sched_state_t          w_state_nxt;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         r_grant;
  logic [2*NUM_CH-1:0]   r_ctx;
  logic [IW-1:0]         r_evt_ch;
  logic                  r_evt_level;

  logic                  w_rr_found;
  logic [IW-1:0]         w_rr_idx;
  logic [1:0]            w_cur_ctx;
  logic [1:0]            w_nxt_ctx;
  logic                  w_in;
  logic                  w_event;

  // ---------------------------------------------------------------------------
  // Round-robin search starting at r_ptr. NUM_CH is a power of two, so the
  // index sum wraps naturally in IW bits.
  // ---------------------------------------------------------------------------
  always_comb begin : rr_search
    logic [IW-1:0] v_idx;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    v_idx      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      v_idx = r_ptr + IW'(i);
      if (!w_rr_found && ch_req[v_idx]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = v_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shared detector operating on the granted channel's context.
  // ---------------------------------------------------------------------------
  assign w_cur_ctx = r_ctx[2*int'(r_grant) +: 2];
  assign w_in      = ch_in[r_grant];

  trans_detect_core u_core (
    .i_state      (w_cur_ctx),
    .i_in         (w_in),
    .o_next_state (w_nxt_ctx),
    .o_event      (w_event)
  );

  // ---------------------------------------------------------------------------
  // Scheduler FSM: next state and Moore outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    ch_ack      = '0;
    evt_valid   = 1'b0;
    case (r_state)
      SCHED_IDLE: begin
        if (w_rr_found) w_state_nxt = SCHED_SERVE;
      end
      SCHED_SERVE: begin
        ch_ack      = NUM_CH'(1) << r_grant;
        w_state_nxt = w_event ? SCHED_EMIT : SCHED_IDLE;
      end
      SCHED_EMIT: begin
        evt_valid = 1'b1;
        if (evt_ready) w_state_nxt = SCHED_IDLE;
      end
      default: w_state_nxt = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= SCHED_IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_evt_ch    <= '0;
      r_evt_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Grant is latched in IDLE; ch_req is not looked at again until the
      // scheduler is back in IDLE, so a dropped request is still served.
      if (r_state == SCHED_IDLE && w_rr_found) begin
        r_grant <= w_rr_idx;
        r_ptr   <= w_rr_idx + 1'b1;
      end
      // Event payload is frozen for the whole EMIT phase.
      if (r_state == SCHED_SERVE && w_event) begin
        r_evt_ch    <= r_grant;
        r_evt_level <= w_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel context registers. A clear wins over a same-cycle SERVE write;
  // the event computed from the old context is still emitted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctx <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ctx_clr[k]) begin
          r_ctx[2*k +: 2] <= CTX_A;
        end else if (r_state == SCHED_SERVE && r_grant == IW'(k)) begin
          r_ctx[2*k +: 2] <= w_nxt_ctx;
        end
      end
    end
  end

  assign evt_ch    = r_evt_ch;
  assign evt_level = r_evt_level;
  assign ctx_state = r_ctx;
  assign dbg_state = r_state;

endmodule : transition_detect_sched

// File: tb/tb_transition_detect_sched.sv
module tb_transition_detect_sched;
  import transition_detect_sched_pkg::*;

  localparam int NUM_CH = 4;
  localparam int IW     = 2;
  localparam int W      = IW + 1;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [NUM_CH-1:0]   ch_req = '0;
  logic [NUM_CH-1:0]   ch_in = '0;
  logic [NUM_CH-1:0]   ch_ack;
  logic [NUM_CH-1:0]   ctx_clr = '0;
  logic                evt_valid;
  logic                evt_ready = 1'b0;
  logic [IW-1:0]       evt_ch;
  logic                evt_level;
  logic [2*NUM_CH-1:0] ctx_state;
  logic [1:0]          dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: last seen level per channel (-1 = none), RR pointer,
  // and queue of expected {channel, level} events.
  int         m_hist[NUM_CH];
  int         m_ptr;
  logic [W-1:0] exp_q[$];

  transition_detect_sched #(.NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_req    (ch_req),
    .ch_in     (ch_in),
    .ch_ack    (ch_ack),
    .ctx_clr   (ctx_clr),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_level (evt_level),
    .ctx_state (ctx_state),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- model helpers ----------------
  function automatic logic [1:0] ctx_code(int h);
    if (h < 0) return 2'b00;
    return (h == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [2*NUM_CH-1:0] model_ctx_vec();
    logic [2*NUM_CH-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_CH; k++) v[2*k +: 2] = ctx_code(m_hist[k]);
    return v;
  endfunction

  function automatic int rr_pick(int ptr, logic [NUM_CH-1:0] req);
    for (int off = 0; off < NUM_CH; off++) begin
      if (req[(ptr + off) % NUM_CH]) return (ptr + off) % NUM_CH;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(logic [NUM_CH-1:0] v);
    int r;
    int n;
    r = -1;
    n = 0;
    for (int i = 0; i < NUM_CH; i++) if (v[i]) begin r = i; n++; end
    return (n == 1) ? r : -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    reset     = 1'b0;
    ch_req    = '0;
    ch_in     = '0;
    ctx_clr   = '0;
    evt_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < NUM_CH; k++) m_hist[k] = -1;
    m_ptr = 0;
    exp_q.delete();
  endtask

  // Waits (bounded) for the next ack pulse; ch = -1 on timeout or non-one-hot.
  task automatic wait_ack(output int ch, output int at_cyc);
    ch = -1;
    at_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ch_ack != '0) begin
        ch = onehot_idx(ch_ack);
        at_cyc = cyc;
        return;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset  = 1'b0;
    ch_req = '1;
    ch_in  = '1;
    evt_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (ch_ack !== '0) begin n_errors++; $display("FAIL reset_ack: got %0h expected 0", ch_ack); end
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0b expected 0", evt_valid); end
    n_checks++; if (evt_ch !== '0) begin n_errors++; $display("FAIL reset_evt_ch: got %0d expected 0", evt_ch); end
    n_checks++; if (evt_level !== 1'b0) begin n_errors++; $display("FAIL reset_evt_level: got %0b expected 0", evt_level); end
    n_checks++; if (ctx_state !== '0) begin n_errors++; $display("FAIL reset_ctx: got %0h expected 0", ctx_state); end
    n_checks++; if (dbg_state !== 2'b00) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    ch_req = '0;
    ch_in  = '0;
  endtask

  task automatic test_single_channel();
    int vals[4];
    int g;
    int c;
    logic exp_evt;
    vals = '{0, 1, 1, 0};
    apply_reset();
    evt_ready = 1'b1;
    ch_in[0]  = 1'(vals[0]);
    ch_req    = 4'b0001;
    @(negedge clk);
    n_checks++; if (ch_ack !== 4'b0001) begin n_errors++; $display("FAIL single_latency: got %0h expected 1", ch_ack); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        wait_ack(g, c);
        n_checks++; if (g !== 0) begin n_errors++; $display("FAIL single_grant%0d: got %0d expected 0", i, g); end
      end
      exp_evt = (m_hist[0] >= 0) && (m_hist[0] != vals[i]);
      m_hist[0] = vals[i];
      @(negedge clk);
      n_checks++; if (evt_valid !== exp_evt) begin n_errors++; $display("FAIL single_evt%0d: got %0b expected %0b", i, evt_valid, exp_evt); end
      if (exp_evt) begin
        n_checks++; if (evt_ch !== 2'd0 || evt_level !== 1'(vals[i])) begin n_errors++; $display("FAIL single_payload%0d: got ch=%0d lvl=%0b expected ch=0 lvl=%0d", i, evt_ch, evt_level, vals[i]); end
      end
      n_checks++; if (ctx_state[1:0] !== ctx_code(m_hist[0])) begin n_errors++; $display("FAIL single_ctx%0d: got %0d expected %0d", i, ctx_state[1:0], ctx_code(m_hist[0])); end
      if (i < 3) ch_in[0] = 1'(vals[i+1]);
    end
    ch_req = '0;
  endtask

  task automatic test_round_robin();
    int g;
    int c;
    int prev;
    int exp;
    apply_reset();
    evt_ready = 1'b1;
    ch_in  = NUM_CH'($urandom);
    ch_req = '1;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_ack(g, c);
      exp = rr_pick(m_ptr, '1);
      m_ptr = (exp + 1) % NUM_CH;
      n_checks++; if (g !== exp) begin n_errors++; $display("FAIL rr_order%0d: got %0d expected %0d", i, g, exp); end
      if (i > 0) begin
        n_checks++; if (c - prev !== 2) begin n_errors++; $display("FAIL rr_spacing%0d: got %0d expected 2", i, c - prev); end
      end
      prev = c;
    end
    ch_req = '0;
  endtask

  task automatic test_stall();
    int g;
    int c;
    apply_reset();
    evt_ready = 1'b1;
    ch_in  = '0;
    ch_req = 4'b0010;
    wait_ack(g, c);
    n_checks++; if (g !== 1) begin n_errors++; $display("FAIL stall_grant_a: got %0d expected 1", g); end
    m_ptr = 2;
    @(negedge clk);
    ch_in[1]  = 1'b1;
    evt_ready = 1'b0;
    wait_ack(g, c);
    n_checks++; if (g !== 1) begin n_errors++; $display("FAIL stall_grant_b: got %0d expected 1", g); end
    ch_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_level !== 1'b1) begin n_errors++; $display("FAIL stall_hold%0d: got v=%0b ch=%0d lvl=%0b expected v=1 ch=1 lvl=1", k, evt_valid, evt_ch, evt_level); end
      n_checks++; if (ch_ack !== '0) begin n_errors++; $display("FAIL stall_noack%0d: got %0h expected 0", k, ch_ack); end
    end
    evt_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL stall_release: got %0b expected 0", evt_valid); end
    wait_ack(g, c);
    n_checks++; if (g !== rr_pick(m_ptr, 4'b1111)) begin n_errors++; $display("FAIL stall_next: got %0d expected %0d", g, rr_pick(m_ptr, 4'b1111)); end
    ch_req = '0;
  endtask

  task automatic test_ctx_clr();
    int g;
    int c;
    apply_reset();
    evt_ready = 1'b1;
    ch_in  = '0;
    ch_req = 4'b0100;
    wait_ack(g, c);
    n_checks++; if (g !== 2) begin n_errors++; $display("FAIL clr_grant_a: got %0d expected 2", g); end
    @(negedge clk);
    n_checks++; if (ctx_state[5:4] !== 2'b01) begin n_errors++; $display("FAIL clr_ctx_b: got %0d expected 1", ctx_state[5:4]); end
    ch_in[2] = 1'b1;
    wait_ack(g, c);
    n_checks++; if (g !== 2) begin n_errors++; $display("FAIL clr_grant_b: got %0d expected 2", g); end
    ctx_clr = 4'b0100;
    @(negedge clk);
    ctx_clr = '0;
    n_checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_level !== 1'b1) begin n_errors++; $display("FAIL clr_event: got v=%0b ch=%0d lvl=%0b expected v=1 ch=2 lvl=1", evt_valid, evt_ch, evt_level); end
    n_checks++; if (ctx_state[5:4] !== 2'b00) begin n_errors++; $display("FAIL clr_ctx_a: got %0d expected 0", ctx_state[5:4]); end
    ch_in[2] = 1'b0;
    wait_ack(g, c);
    n_checks++; if (g !== 2) begin n_errors++; $display("FAIL clr_grant_c: got %0d expected 2", g); end
    @(negedge clk);
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL clr_no_event: got %0b expected 0", evt_valid); end
    n_checks++; if (ctx_state[5:4] !== 2'b01) begin n_errors++; $display("FAIL clr_ctx_after: got %0d expected 1", ctx_state[5:4]); end
    ch_req = '0;
  endtask

  task automatic test_reset_in_emit();
    int g;
    int c;
    apply_reset();
    evt_ready = 1'b0;
    ch_in  = '0;
    ch_req = 4'b0010;
    wait_ack(g, c);
    n_checks++; if (g !== 1) begin n_errors++; $display("FAIL rst_emit_grant_a: got %0d expected 1", g); end
    @(negedge clk);
    ch_in[1] = 1'b1;
    wait_ack(g, c);
    n_checks++; if (g !== 1) begin n_errors++; $display("FAIL rst_emit_grant_b: got %0d expected 1", g); end
    @(negedge clk);
    n_checks++; if (evt_valid !== 1'b1) begin n_errors++; $display("FAIL rst_emit_pending: got %0b expected 1", evt_valid); end
    ch_req = 4'b1111;
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL rst_emit_valid: got %0b expected 0", evt_valid); end
    n_checks++; if (ctx_state !== '0) begin n_errors++; $display("FAIL rst_emit_ctx: got %0h expected 0", ctx_state); end
    n_checks++; if (evt_ch !== '0 || evt_level !== 1'b0) begin n_errors++; $display("FAIL rst_emit_payload: got ch=%0d lvl=%0b expected ch=0 lvl=0", evt_ch, evt_level); end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < NUM_CH; k++) m_hist[k] = -1;
    m_ptr = 0;
    wait_ack(g, c);
    n_checks++; if (g !== 0) begin n_errors++; $display("FAIL rst_emit_ptr: got %0d expected 0", g); end
    ch_req = '0;
  endtask

  task automatic test_random();
    int phase;   // 0 idle, 1 service cycle, 2 event outstanding
    int g_exp;
    int n_serv;
    int p;
    logic v;
    logic ev;
    logic stop;
    logic [NUM_CH-1:0] exp_ack;
    apply_reset();
    phase  = 0;
    g_exp  = 0;
    n_serv = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      n_checks++; if (ctx_state !== model_ctx_vec()) begin n_errors++; $display("FAIL rand_ctx t=%0d: got %0h expected %0h", t, ctx_state, model_ctx_vec()); end
      exp_ack = (phase == 1) ? (NUM_CH'(1) << g_exp) : '0;
      n_checks++; if (ch_ack !== exp_ack) begin n_errors++; $display("FAIL rand_ack t=%0d: got %0h expected %0h", t, ch_ack, exp_ack); end
      n_checks++; if (evt_valid !== (phase == 2)) begin n_errors++; $display("FAIL rand_valid t=%0d: got %0b expected %0b", t, evt_valid, phase == 2); end
      if (phase == 2 && exp_q.size() > 0) begin
        n_checks++; if ({evt_ch, evt_level} !== exp_q[0]) begin n_errors++; $display("FAIL rand_payload t=%0d: got %0h expected %0h", t, {evt_ch, evt_level}, exp_q[0]); end
      end
      // drive next cycle
      stop      = (t >= 2800);
      ch_in     = NUM_CH'($urandom);
      evt_ready = stop ? 1'b1 : ($urandom_range(0, 2) != 0);
      ctx_clr   = (!stop && $urandom_range(0, 15) == 0) ? (NUM_CH'(1) << $urandom_range(0, NUM_CH-1)) : '0;
      if (phase == 1 && $urandom_range(0, 1) == 1) ch_req[g_exp] = 1'b0;
      if (stop) ch_req = '0;
      else ch_req = ch_req | NUM_CH'($urandom_range(0, 15) & $urandom_range(0, 15));
      // advance model
      case (phase)
        1: begin
          v  = ch_in[g_exp];
          ev = (m_hist[g_exp] >= 0) && (m_hist[g_exp] != int'(v));
          m_hist[g_exp] = int'(v);
          n_serv++;
          if (ev) begin
            exp_q.push_back({IW'(g_exp), v});
            phase = 2;
          end else begin
            phase = 0;
          end
        end
        2: begin
          if (evt_ready) begin
            void'(exp_q.pop_front());
            phase = 0;
          end
        end
        default: begin
          p = rr_pick(m_ptr, ch_req);
          if (p >= 0) begin
            g_exp = p;
            m_ptr = (p + 1) % NUM_CH;
            phase = 1;
          end
        end
      endcase
      for (int k = 0; k < NUM_CH; k++) if (ctx_clr[k]) m_hist[k] = -1;
    end
    n_checks++; if (exp_q.size() !== 0) begin n_errors++; $display("FAIL rand_drain: got %0d pending expected 0", exp_q.size()); end
    n_checks++; if (n_serv < 100) begin n_errors++; $display("FAIL rand_activity: got %0d services expected >=100", n_serv); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_channel();
    test_round_robin();
    test_stall();
    test_ctx_clr();
    test_reset_in_emit();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_transition_detect_sched
